// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath blocks.
// Holds the product normalizer FSM state encoding.
package mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/product_normalizer.sv
// product_normalizer
//   Converts a redundant product (2*NUM_ELEMENTS limbs of BIT_LEN bits, limb i
//   weighted 2^(i*WORD_LEN)) into canonical WORD_LEN-bit words, streamed least
//   significant first, by rippling a carry through one limb per handshake.
//
//   state | meaning
//   IDLE  | ready for a new product, no output
//   RUN   | emitting word idx, product registers frozen against M
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   in_valid     product present on M
//   in_ready     product accepted this cycle
//   M            redundant product limbs
//   out_valid    out_word valid
//   out_ready    downstream accepts out_word
//   out_word     canonical word
//   out_last     final word of the product
//   out_overflow residual carry beyond the top word is non-zero (with out_last)
module product_normalizer
  import mult_pkg::*;
#(
  parameter int NUM_ELEMENTS = 17,
  parameter int BIT_LEN      = 17,
  parameter int WORD_LEN     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_LEN-1:0]  M [2*NUM_ELEMENTS],
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_LEN-1:0] out_word,
  output logic                out_last,
  output logic                out_overflow
);

  localparam int NUM_LIMBS = 2 * NUM_ELEMENTS;
  localparam int IDX_W     = $clog2(NUM_LIMBS);
  localparam int SUM_W     = BIT_LEN + 1;
  localparam int CARRY_W   = BIT_LEN - WORD_LEN + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIMBS - 1);

  if (BIT_LEN <= WORD_LEN) begin : g_param_check
    $error("product_normalizer: BIT_LEN must exceed WORD_LEN");
  end

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CARRY_W-1:0]   carry_q, carry_d;
  logic [BIT_LEN-1:0]   limb_q [NUM_LIMBS];
  logic                 load;
  logic [SUM_W-1:0]     sum;
  logic                 run;
  logic                 last;

  assign run  = (state_q == RUN);
  assign last = run && (idx_q == LAST_IDX);
  assign sum  = SUM_W'(limb_q[idx_q]) + SUM_W'(carry_q);

  // in_ready is held low while reset is applied, not just after the reset edge.
  assign in_ready     = rst_n && (state_q == IDLE);
  assign out_valid    = run;
  assign out_word     = run ? sum[WORD_LEN-1:0] : '0;
  assign out_last     = last;
  assign out_overflow = last && (sum[SUM_W-1:WORD_LEN] != '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          idx_d   = '0;
          carry_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (out_ready) begin
          carry_d = sum[SUM_W-1:WORD_LEN];
          // idx stops at the top limb; leaving RUN makes wrap impossible.
          if (last) state_d = IDLE;
          else      idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= '0;
      for (int i = 0; i < NUM_LIMBS; i++) limb_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      if (load) begin
        for (int i = 0; i < NUM_LIMBS; i++) limb_q[i] <= M[i];
      end
    end
  end

endmodule

// File: doc/product_normalizer.md
PRODUCT_NORMALIZER -- requirements
Module: product_normalizer

Interface
REQ-001 Parameter NUM_ELEMENTS, default 17: operand limb count; the product has 2*NUM_ELEMENTS limbs.
REQ-002 Parameter BIT_LEN, default 17: width of each redundant product limb.
REQ-003 Parameter WORD_LEN, default 16: canonical word width; BIT_LEN > WORD_LEN SHALL hold, checked at elaboration.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  a redundant product is presented on M.
REQ-007 in_ready  output  1  the block accepts a product this cycle.
REQ-008 M  input  unpacked [2*NUM_ELEMENTS] x BIT_LEN  redundant limbs; limb i has weight 2^(i*WORD_LEN).
REQ-009 out_valid  output  1  out_word holds a valid canonical word.
REQ-010 out_ready  input  1  downstream accepts out_word.
REQ-011 out_word  output  WORD_LEN  canonical word, least significant first.
REQ-012 out_last  output  1  marks word index 2*NUM_ELEMENTS-1.
REQ-013 out_overflow  output  1  qualified by out_last; the residual carry beyond the top word is non-zero.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and RUN.
REQ-015 In IDLE, in_ready=1 and out_valid=0; on in_valid && in_ready, the block SHALL register all 2*NUM_ELEMENTS limbs, clear carry and index, and go to RUN.
REQ-016 In RUN, in_ready=0 and out_valid=1; M SHALL be ignored.
REQ-017 In RUN: sum = limb[idx] + carry, width BIT_LEN+1, zero-extended.
REQ-018 out_word = sum[WORD_LEN-1:0], from registered state only; no combinational path from M or out_ready to any output.
REQ-019 On out_valid && out_ready: carry <= sum >> WORD_LEN (width BIT_LEN-WORD_LEN+1, no truncation); idx <= idx+1.
REQ-020 While out_ready=0, out_word, out_last, out_overflow, idx and carry SHALL hold stable.
REQ-021 out_last=1 iff RUN and idx == 2*NUM_ELEMENTS-1.
REQ-022 out_overflow = out_last && (sum >> WORD_LEN) != 0; it is 0 at all other times.
REQ-023 A handshake with out_last=1 SHALL return the FSM to IDLE.
REQ-024 Latency: the first word is valid in the cycle after input acceptance; with out_ready held high, one word per cycle and 2*NUM_ELEMENTS+1 cycles per product including the IDLE acceptance cycle.
REQ-025 idx width = $clog2(2*NUM_ELEMENTS); no wrap-around past 2*NUM_ELEMENTS-1 is possible.
REQ-026 in_valid asserted in RUN SHALL neither be accepted nor disturb the product in flight.

Reset
REQ-027 While rst_n=0 at a clock edge: state=IDLE; idx, carry and limb registers = 0; out_valid=0, out_word=0, out_last=0, out_overflow=0; in_ready=0 during reset.
REQ-028 Reset asserted mid-RUN SHALL abort the product with no further words emitted; in_ready=1 in the first cycle after rst_n returns high.

Structure
REQ-029 The state enum typedef (IDLE, RUN) SHALL live in the shared package mult_pkg; widths SHALL be localparams derived from the module parameters.
REQ-030 No sub-module is required; the limb register file, carry adder and FSM SHALL be a single module.

Verification
REQ-031 All limbs 0, out_ready=1 -> 34 words of 0x0000; out_last only on the 34th word; out_overflow=0.
REQ-032 M[0]=0x1FFFF, other limbs 0 -> words 0xFFFF, 0x0001, then 32 x 0x0000; out_overflow=0.
REQ-033 All limbs 0x1FFFF -> words 0xFFFF, 0x0000, then 32 x 0x0001; carry stays 2; last word 0x0001 with out_overflow=1.
REQ-034 Case REQ-032 with out_ready toggled pseudo-randomly -> identical word sequence; outputs stable during stalls; in_valid held high in RUN is not accepted.
REQ-035 rst_n low for one cycle after word 5 of REQ-033 -> outputs zero; next accepted product (REQ-032) streams correctly from word 0.
REQ-036 Back-to-back in_valid -> exactly one idle cycle (in_ready=1, out_valid=0) between the 34th word of one product and the first word of the next.
